rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Rotating-priority search over the request vector, with a registered grant.
- Grant holds until the holder releases or a hold limit expires.
- Supplies the encoded grant index and a valid flag.
- Sits in front of any shared datapath (bus, memory port) that previously took a fixed-priority 8-to-3 encoded select.

Parameters:
- MAX_HOLD, 16, maximum cycles one grant may remain asserted. Legal range 2..256.
- CNT_W, 8, width of the internal hold counter. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high = requester i wants the resource.
- release  input  1  current holder finished; sampled only in GRANT state.
- gnt  output  8  one-hot grant, registered.
- gnt_id  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is asserted; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant ends by hold-limit expiry.

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything, including mid-grant:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State=IDLE, hold counter=0, priority pointer ptr=0.
  - The first edge with rst=0 behaves as IDLE.
- Internal state:
  - ptr (3 bits): highest-priority index for the next arbitration.
  - hold counter cnt (CNT_W bits).
  - State machine with two states: IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; outputs stay 0.
  - Else select the first set bit found searching ptr, ptr+1, ..., 7, 0, ..., ptr-1, with indices taken modulo 8.
  - On the next edge: gnt = one-hot of the winner, gnt_id = winner, gnt_valid=1, cnt=0, state=GRANT.
  - Grant latency is one cycle from request sampled to gnt visible.
- GRANT. Exit conditions are evaluated each edge in this priority order:
  1. req[gnt_id]==0 or release==1: normal end. timeout stays 0.
  2. cnt==MAX_HOLD-1: forced end. timeout=1 for exactly the next cycle.
  3. Otherwise stay in GRANT, cnt=cnt+1, outputs unchanged.
- On any exit (next edge):
  - gnt=0, gnt_valid=0, gnt_id keeps its last value.
  - ptr = (gnt_id+1) mod 8, wrapping 7 to 0.
  - cnt=0, state=IDLE.
- Grant duration and turnaround:
  - A grant is high for at most MAX_HOLD consecutive cycles.
  - There is always at least one dead cycle (gnt=0) between consecutive grants, so the resource gets a clean turnaround.
- Simultaneous events:
  - release together with cnt==MAX_HOLD-1 counts as a normal end; no timeout.
  - Changes to other req bits during GRANT are ignored until the next arbitration.
  - release while in IDLE is ignored.
- Fairness: a requester holding req high continuously is granted within 7 other grants.
- timeout is registered and is never high in the same cycle as gnt_valid.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and idle:
  - Assert rst for 2 cycles with req=8'hFF → all outputs 0.
  - Release rst with req=0 → outputs remain 0 for 5 cycles.
- Rotation:
  - From reset, hold req=8'b1000_0101, and pulse release one cycle after each grant.
  - Required gnt_id sequence: 0, 2, 7, 0, 2.
  - Each grant is 2 cycles high with 1 dead cycle between grants; ptr after the 7 grant wraps to 0.
- Single requester latency:
  - Set req=8'h10 at cycle t → gnt=8'h10, gnt_id=4, gnt_valid=1 at t+1.
  - Drop req[4] at t+3 → gnt=0 at t+4, and req=8'h10 again → regrant at t+5.
- Hold-limit timeout, MAX_HOLD=16:
  - req=8'h02 held, release=0 → gnt high for exactly 16 cycles, then timeout=1 for 1 cycle with gnt=0.
  - Requester 1 is regranted the cycle after the timeout pulse if it is still the only requester.
- Release racing timeout:
  - Assert release on grant cycle 16 → grant ends with timeout=0.
- Reset mid-grant:
  - rst during an active grant to requester 5 → next cycle gnt=0.
  - With req=8'hFF after reset → grant goes to 0 (ptr reset), not 6.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, hold limit
// and timeout pulse. The holder's "release" input is named rel ("release" is a reserved word).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; arbitrate on any request, searching from ptr
// S_GRANT | gnt held; ends on drop/rel (normal) or hold limit (timeout)
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       win;
  logic [2:0]       idx;
  logic             found;
  logic             hold_tc;

  assign hold_tc = (cnt == CNT_W'(MAX_HOLD - 1));

  // Rotating search: first set bit at ptr, ptr+1, ... wrapping through 7 to 0.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timeout <= 1'b0;
          cnt     <= '0;
          if (found) begin
            gnt       <= 8'(1) << win;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!req[gnt_id] || rel || hold_tc) begin
            // A normal end wins over the hold limit when both happen together.
            timeout   <= req[gnt_id] && !rel;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 3'd1;
            cnt       <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: vector table, hand-written corner sequences and
// random traffic compared against a cycle-level reference model.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_on;
  int m_id, m_ptr, m_held;
  bit m_to;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         rel;
    logic [7:0] e_gnt;
    logic [2:0] e_id;
    bit         e_valid;
    bit         e_to;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    bit done;
    if (rst) begin
      m_on = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (!m_on) begin
      m_to = 0;
      if (req != 8'h00) begin
        done = 0;
        for (int k = 0; k < 8; k++)
          if (!done && req[(m_ptr + k) % 8]) begin
            m_id = (m_ptr + k) % 8;
            done = 1;
          end
        m_on = 1;
        m_held = 1;
      end
    end else begin
      m_to = 0;
      if (!req[m_id] || rel) begin
        m_on = 0; m_ptr = (m_id + 1) % 8; m_held = 0;
      end else if (m_held == MAX_HOLD) begin
        m_on = 0; m_ptr = (m_id + 1) % 8; m_held = 0; m_to = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step();
    logic [7:0] eg;
    @(posedge clk);
    #1;
    model_edge();
    eg = m_on ? (8'h01 << m_id) : 8'h00;
    chk("model_gnt", gnt, eg);
    chk("model_gnt_id", gnt_id, m_id[2:0]);
    chk("model_gnt_valid", gnt_valid, m_on);
    chk("model_timeout", timeout, m_to);
  endtask

  task automatic add(input bit r, input logic [7:0] q, input bit l,
                     input logic [7:0] g, input logic [2:0] id, input bit v, input bit t);
    vec_t x;
    x.rst = r; x.req = q; x.rel = l; x.e_gnt = g; x.e_id = id; x.e_valid = v; x.e_to = t;
    vecs.push_back(x);
  endtask

  initial begin
    int hi_cnt;
    bit seen_to;

    // reset with all requests, then idle
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 8'h00, 0, 0, 0);
    // rotation over 0,2,7 with release on each grant's second cycle
    add(0, 8'h85, 0, 8'h01, 0, 1, 0); add(0, 8'h85, 0, 8'h01, 0, 1, 0); add(0, 8'h85, 1, 8'h00, 0, 0, 0);
    add(0, 8'h85, 0, 8'h04, 2, 1, 0); add(0, 8'h85, 0, 8'h04, 2, 1, 0); add(0, 8'h85, 1, 8'h00, 2, 0, 0);
    add(0, 8'h85, 0, 8'h80, 7, 1, 0); add(0, 8'h85, 0, 8'h80, 7, 1, 0); add(0, 8'h85, 1, 8'h00, 7, 0, 0);
    add(0, 8'h85, 0, 8'h01, 0, 1, 0); add(0, 8'h85, 0, 8'h01, 0, 1, 0); add(0, 8'h85, 1, 8'h00, 0, 0, 0);
    add(0, 8'h85, 0, 8'h04, 2, 1, 0); add(0, 8'h85, 0, 8'h04, 2, 1, 0); add(0, 8'h85, 1, 8'h00, 2, 0, 0);
    // single requester: latency, drop, regrant
    add(0, 8'h00, 0, 8'h00, 2, 0, 0);
    add(0, 8'h10, 0, 8'h10, 4, 1, 0); add(0, 8'h10, 0, 8'h10, 4, 1, 0); add(0, 8'h10, 0, 8'h10, 4, 1, 0);
    add(0, 8'h00, 0, 8'h00, 4, 0, 0);
    add(0, 8'h10, 0, 8'h10, 4, 1, 0);
    add(0, 8'h00, 0, 8'h00, 4, 0, 0); add(0, 8'h00, 1, 8'h00, 4, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; rel = vecs[i].rel;
      step();
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d_gnt_id", i), gnt_id, vecs[i].e_id);
      chk($sformatf("vec%0d_valid", i), gnt_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_timeout", i), timeout, vecs[i].e_to);
    end

    // hold-limit timeout with a single requester
    req = 8'h02; rel = 0;
    hi_cnt = 0; seen_to = 0;
    for (int i = 0; i < 40 && !seen_to; i++) begin
      step();
      if (gnt_valid) hi_cnt++;
      if (timeout) seen_to = 1;
    end
    chk("to_seen", seen_to, 1);
    chk("to_hold_cycles", hi_cnt, MAX_HOLD);
    chk("to_gnt_low", gnt_valid, 0);
    step();
    chk("to_regrant_gnt", gnt, 8'h02);
    chk("to_regrant_pulse_end", timeout, 0);

    // release on the last allowed grant cycle ends normally
    for (int i = 0; i < MAX_HOLD - 1; i++) step();
    chk("race_still_granted", gnt_valid, 1);
    rel = 1;
    step();
    chk("race_gnt_off", gnt, 8'h00);
    chk("race_no_timeout", timeout, 0);
    rel = 0; req = 8'h00;
    step();

    // reset during a grant to requester 5
    req = 8'h20;
    step();
    chk("mid_gnt5", gnt_id, 3'd5);
    step();
    rst = 1;
    step();
    chk("mid_rst_gnt", gnt, 8'h00);
    rst = 0; req = 8'hFF;
    step();
    chk("post_rst_id", gnt_id, 3'd0);
    chk("post_rst_gnt", gnt, 8'h01);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: req = 8'h00;
        1: req = 8'(1) << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) req = 8'hFF;
      rel = ($urandom_range(0, 4) == 0);
      if (i % 500 < 60) rel = 0;
      step();
      if (timeout && gnt_valid) chk("to_with_valid", {timeout, gnt_valid}, 2'b10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
